uart_tx_arbiter: RTL and testbench

Message-granular round-robin arbiter that shares one `uart_tx` instance among `NUM_REQ` byte-stream requesters, e.g. a dice result logger, a status reporter and a debug echo. It sits between the requester logic and `uart_tx`. Once a requester is granted, it keeps the transmitter until it sends a byte flagged `last`, so messages are never interleaved. It issues the transmitter's single-cycle `valid` pulses and returns per-requester `ready` strobes.

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// ============================================================================
// uart_arb_pkg -- shared types and helpers for the UART transmit arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 8;

  function automatic int grant_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ============================================================================
// rr_pick -- rotate-priority encoder: first requester at or after last_grant+1
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      winner,
  output logic               any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req[idx]) begin
        winner = GW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter -- message-granular round-robin share of one uart_tx.
// Optional idle-owner release: define UART_TX_ARBITER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [8*NUM_REQ-1:0]         req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [grant_w(NUM_REQ)-1:0]  grant_id,
  output logic                         busy
);

  localparam int GW = grant_w(NUM_REQ);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] pick_winner;
  logic          pick_any;
  logic          owner_valid;
  logic          owner_last;
  logic [7:0]    owner_data;
  logic          accept;
  logic          release_lock;
  logic          timed_out;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (pick_winner),
    .any        (pick_any)
  );

  always_comb begin
    owner_valid = req_valid[grant_id];
    owner_last  = req_last[grant_id];
    owner_data  = req_data[{grant_id, 3'b000} +: 8];
  end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] idle_cnt;

  // Released on the stall cycle that brings the count to TIMEOUT_CYCLES.
  assign timed_out = (state == LOCKED) && !owner_valid &&
                     (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state == IDLE || accept) begin
      idle_cnt <= '0;
    end else if (!owner_valid) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    accept       = 1'b0;
    release_lock = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = LOCKED;
      end
      LOCKED: begin
        // tx_valid guard covers the cycle before uart_tx drops tx_ready.
        accept = owner_valid && tx_ready && !tx_valid;
        if (accept) req_ready[grant_id] = 1'b1;
        if ((accept && owner_last) || timed_out) begin
          release_lock = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      busy       <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      tx_valid <= accept;
      if (accept) tx_data <= owner_data;
      if (state == IDLE && pick_any) begin
        grant_id <= pick_winner;
        busy     <= 1'b1;
      end
      if (release_lock) begin
        last_grant <= grant_id;
        busy       <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter -- directed self-checking bench for uart_tx_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Per-lane message buffers: bit 8 flags the last byte.
  logic [8:0] mbuf [4][8];
  int         head [4];
  int         len  [4];
  logic [3:0] stall;
  logic       force_all;

  logic [3:0] smp_ready;
  logic       smp_txv;
  logic [7:0] smp_txd;
  logic       smp_busy;
  logic [1:0] smp_gid;
  logic [7:0] tx_log[$];
  int         acc_log[$];
  int         n;
  int         bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int lane, input int cnt, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] b2);
    mbuf[lane][0] = {(cnt == 1), b0};
    mbuf[lane][1] = {(cnt == 2), b1};
    mbuf[lane][2] = {(cnt == 3), b2};
    head[lane] = 0;
    len[lane]  = cnt;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    acc_log.delete();
  endtask

  function automatic bit pending();
    for (int i = 0; i < 4; i++) if (head[i] < len[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_lanes();
    for (int i = 0; i < 4; i++) begin
      logic [8:0] e;
      e = (head[i] < len[i]) ? mbuf[i][head[i]] : 9'h000;
      req_valid[i]     = force_all || ((head[i] < len[i]) && !(stall[i] && head[i] >= 1));
      req_data[8*i+:8] = e[7:0];
      req_last[i]      = e[8];
    end
  endtask

  // Drive at posedge+1, sample at posedge+2, consume accepted bytes, step.
  task automatic cycle();
    drive_lanes();
    #1;
    smp_ready = req_ready;
    smp_txv   = tx_valid;
    smp_txd   = tx_data;
    smp_busy  = busy;
    smp_gid   = grant_id;
    if (smp_txv) tx_log.push_back(smp_txd);
    for (int i = 0; i < 4; i++) begin
      if (smp_ready[i]) begin
        acc_log.push_back(i);
        head[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    tx_ready = 1'b1;
    force_all = 1'b1;
    stall = 4'b0000;
    req_valid = 4'hF;
    req_data = '0;
    req_last = '0;
    for (int i = 0; i < 4; i++) begin head[i] = 0; len[i] = 0; end
    @(posedge clk);
    #1;

    // Reset held with every lane requesting.
    repeat (3) begin
      cycle();
      chk("rst_busy", smp_busy, 0);
      chk("rst_txv", smp_txv, 0);
      chk("rst_ready", smp_ready, 0);
    end

    // Lanes 0 and 2 both hold 3-byte messages; 0 wins first after reset.
    rst_n = 1'b1;
    force_all = 1'b0;
    clear_logs();
    load(0, 3, 8'hA1, 8'hA2, 8'hA3);
    load(2, 3, 8'hC1, 8'hC2, 8'hC3);
    cycle();
    chk("idle_no_move", smp_ready, 0);
    chk("idle_busy", smp_busy, 0);
    cycle();
    chk("first_gid", smp_gid, 0);
    chk("first_ready", smp_ready, 4'b0001);
    chk("first_busy", smp_busy, 1);
    n = 0;
    while (pending() && n < 100) begin cycle(); n++; end
    cycle();
    cycle();
    chk("rr_n_acc", acc_log.size(), 6);
    chk("rr_acc0", acc_log[0], 0);
    chk("rr_acc2", acc_log[2], 0);
    chk("rr_acc3", acc_log[3], 2);
    chk("rr_acc5", acc_log[5], 2);
    chk("rr_n_tx", tx_log.size(), 6);
    chk("rr_tx0", tx_log[0], 8'hA1);
    chk("rr_tx2", tx_log[2], 8'hA3);
    chk("rr_tx3", tx_log[3], 8'hC1);
    chk("rr_tx5", tx_log[5], 8'hC3);

    // Requester 1 sends "Hi\n".
    clear_logs();
    load(1, 3, 8'h48, 8'h69, 8'h0A);
    n = 0;
    while (pending() && n < 50) begin cycle(); n++; end
    cycle();
    chk("hi_last_txv", smp_txv, 1);
    chk("hi_last_txd", smp_txd, 8'h0A);
    chk("hi_busy_drop", smp_busy, 0);
    cycle();
    chk("hi_n_tx", tx_log.size(), 3);
    chk("hi_tx0", tx_log[0], 8'h48);
    chk("hi_tx1", tx_log[1], 8'h69);
    chk("hi_tx2", tx_log[2], 8'h0A);
    chk("hi_acc_lane", acc_log[0] + acc_log[1] + acc_log[2], 3);

    // tx_ready low for 100 cycles with lane 3 valid.
    tx_ready = 1'b0;
    clear_logs();
    load(3, 2, 8'h33, 8'h34, 8'h00);
    bad = 0;
    repeat (100) begin
      cycle();
      if (smp_ready != 4'b0000 || smp_txv) bad++;
    end
    chk("stall_quiet", bad, 0);
    chk("stall_owner", smp_gid, 3);
    chk("stall_busy", smp_busy, 1);
    tx_ready = 1'b1;
    cycle();
    chk("unstall_ready", smp_ready, 4'b1000);
    cycle();
    chk("launch_txv", smp_txv, 1);
    chk("launch_txd", smp_txd, 8'h33);
    chk("guard_no_ready", smp_ready, 4'b0000);
    cycle();
    chk("second_ready", smp_ready, 4'b1000);
    cycle();
    chk("second_txd", smp_txd, 8'h34);
    chk("second_busy", smp_busy, 0);

    // Reset pulsed mid-message, then a fresh request.
    clear_logs();
    load(0, 3, 8'hD0, 8'hD1, 8'hD2);
    cycle();
    cycle();
    chk("mid_ready", smp_ready, 4'b0001);
    rst_n = 1'b0;
    len[0] = 0;
    cycle();
    rst_n = 1'b1;
    clear_logs();
    load(2, 2, 8'hE0, 8'hE1, 8'h00);
    cycle();
    chk("mid_rst_busy", smp_busy, 0);
    chk("mid_rst_txv", smp_txv, 0);
    chk("mid_rst_ready", smp_ready, 0);
    n = 0;
    while (pending() && n < 50) begin cycle(); n++; end
    cycle();
    chk("regrant_n_acc", acc_log.size(), 2);
    chk("regrant_lane", acc_log[0], 2);
    chk("regrant_tx0", tx_log[0], 8'hE0);
    chk("regrant_tx1", tx_log[1], 8'hE1);
    chk("regrant_busy", smp_busy, 0);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    // Owner 0 stalls after byte 1; lane 3 must take over after the timeout.
    load(3, 1, 8'hF0, 8'h00, 8'h00);
    n = 0;
    while (pending() && n < 20) begin cycle(); n++; end
    cycle();
    clear_logs();
    stall = 4'b0001;
    load(0, 3, 8'h70, 8'h71, 8'h72);
    load(3, 1, 8'hF1, 8'h00, 8'h00);
    n = 0;
    while (head[3] < len[3] && n < 200) begin cycle(); n++; end
    cycle();
    chk("to_n_acc", acc_log.size(), 2);
    chk("to_first", acc_log[0], 0);
    chk("to_next", acc_log[1], 3);
    chk("to_tx1", tx_log[1], 8'hF1);
    chk("to_busy", smp_busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
